instr_encoder: RTL and testbench

Streaming MIPS instruction encoder: accepts one symbolic instruction per handshake (operation id plus register/immediate/target fields) and packs it into a 32-bit machine word. Writes it into instruction memory at an auto-incrementing word address. It is the producing end of the opcode map the control decoder consumes. Used by the test/boot path to build programs in instruction memory without a host-side assembler.

---
 rtl/isa_pkg.sv | 52 +++++
 rtl/instr_pack.sv | 46 ++++
 rtl/instr_encoder.sv | 82 ++++++++
 tb/tb_instr_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// MIPS opcode map shared by the instruction encoder and the control decoder.
// Holds primary opcodes, the JR funct code and the encoder's op-id enum.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;

    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;

    typedef enum logic [4:0] {
        ID_RTYPE = 5'd0,
        ID_ADDI  = 5'd1,
        ID_ANDI  = 5'd2,
        ID_ORI   = 5'd3,
        ID_XORI  = 5'd4,
        ID_LW    = 5'd5,
        ID_SW    = 5'd6,
        ID_SB    = 5'd7,
        ID_LB    = 5'd8,
        ID_SH    = 5'd9,
        ID_LH    = 5'd10,
        ID_BGEZ  = 5'd11,
        ID_BLTZ  = 5'd12,
        ID_BEQ   = 5'd13,
        ID_BNE   = 5'd14,
        ID_BGTZ  = 5'd15,
        ID_BLEZ  = 5'd16,
        ID_J     = 5'd17,
        ID_JAL   = 5'd18,
        ID_JR    = 5'd19
    } op_id_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: symbolic op id plus fields to a 32-bit MIPS word.
// legal drops low for op ids outside the encoder's map.
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (op)
            ID_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            ID_ADDI:  word = {OP_ADDI, rs, rt, imm};
            ID_ANDI:  word = {OP_ANDI, rs, rt, imm};
            ID_ORI:   word = {OP_ORI, rs, rt, imm};
            ID_XORI:  word = {OP_XORI, rs, rt, imm};
            ID_LW:    word = {OP_LW, rs, rt, imm};
            ID_SW:    word = {OP_SW, rs, rt, imm};
            ID_SB:    word = {OP_SB, rs, rt, imm};
            ID_LB:    word = {OP_LB, rs, rt, imm};
            ID_SH:    word = {OP_SH, rs, rt, imm};
            ID_LH:    word = {OP_LH, rs, rt, imm};
            ID_BGEZ:  word = {OP_REGIMM, rs, RT_BGEZ, imm};
            ID_BLTZ:  word = {OP_REGIMM, rs, RT_BLTZ, imm};
            ID_BEQ:   word = {OP_BEQ, rs, rt, imm};
            ID_BNE:   word = {OP_BNE, rs, rt, imm};
            ID_BGTZ:  word = {OP_BGTZ, rs, 5'd0, imm};
            ID_BLEZ:  word = {OP_BLEZ, rs, 5'd0, imm};
            ID_J:     word = {OP_J, target};
            ID_JAL:   word = {OP_JAL, target};
            ID_JR:    word = {OP_RTYPE, rs, 15'd0, FUNCT_JR};
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs one symbolic instruction per handshake
// and writes it to instruction memory at an auto-incrementing address.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_DEFAULT = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic              err_pulse,
    output logic [15:0]       word_count
);

    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        complete;

    instr_pack u_pack (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .word   (word),
        .legal  (legal)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = out_valid && out_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid  <= 1'b0;
            out_data   <= 32'h0;
            out_addr   <= BASE_DEFAULT;
            err_pulse  <= 1'b0;
            word_count <= 16'h0;
        end else begin
            err_pulse <= accept && !legal;

            if (accept && legal) begin
                out_valid <= 1'b1;
                out_data  <= word;
            end else if (complete) begin
                out_valid <= 1'b0;
            end

            // out_addr always names the pending (or next) word's slot
            if (complete) begin
                out_addr <= out_addr + ADDR_W'(4);
                if (word_count != 16'hFFFF)
                    word_count <= word_count + 16'd1;
            end else if (base_load && !out_valid) begin
                out_addr   <= base_addr;
                word_count <= 16'h0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed machine words.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_encoder;
    import isa_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        base_load;
    logic [31:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        err_pulse;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;

    instr_encoder #(
        .ADDR_W       (32),
        .BASE_DEFAULT (32'h0000_0000)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .base_load  (base_load),
        .base_addr  (base_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .err_pulse  (err_pulse),
        .word_count (word_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm, input logic [25:0] tgt);
        in_valid  = 1'b1;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_funct  = fn;
        in_imm    = imm;
        in_target = tgt;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    // One accepted word with out_ready=1: check the word, then completion
    task automatic one(input string tag, input logic [4:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] exp,
                       input logic [31:0] addr);
        drive(op, rs, rt, rd, sh, fn, imm, tgt);
        @(negedge Clk);
        idle();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_addr"}, out_addr, addr);
        @(negedge Clk);
    endtask

    logic [31:0] a_hold;
    logic [31:0] d_hold;
    logic [15:0] c_hold;

    initial begin
        Rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_shamt  = '0;
        in_funct  = '0;
        in_imm    = '0;
        in_target = '0;
        base_load = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;

        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_addr", out_addr, 32'h0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // ADDI $2,$1,5
        one("addi", ID_ADDI, 5'd1, 5'd2, 5'd9, 5'd3, 6'h3F, 16'h0005,
            26'h0, 32'h2022_0005, 32'h0);
        chk("addi_count", 32'(word_count), 32'd1);
        chk("addi_addr_next", out_addr, 32'h4);
        chk("addi_done", 32'(out_valid), 32'd0);

        // RTYPE then LW back-to-back
        do_reset();
        drive(ID_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h3FF_FFFF);
        @(negedge Clk);
        chk("rtype_data", out_data, 32'h0022_1820);
        chk("rtype_addr", out_addr, 32'h0);
        drive(ID_LW, 5'd29, 5'd8, 5'd7, 5'd5, 6'h11, 16'h0004, 26'h0);
        @(negedge Clk);
        idle();
        chk("lw_valid", 32'(out_valid), 32'd1);
        chk("lw_data", out_data, 32'h8FA8_0004);
        chk("lw_addr", out_addr, 32'h4);
        @(negedge Clk);
        chk("b2b_count", 32'(word_count), 32'd2);
        chk("b2b_addr", out_addr, 32'h8);

        // Forced-field and jump encodings
        one("bgez", ID_BGEZ, 5'd3, 5'd7, 5'd0, 5'd0, 6'h0, 16'hFFFC,
            26'h0, 32'h0461_FFFC, 32'h8);
        one("jr", ID_JR, 5'd31, 5'd4, 5'd5, 5'd6, 6'h2A, 16'h1234,
            26'h0, 32'h03E0_0008, 32'hC);
        one("j", ID_J, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF,
            26'h010_0000, 32'h0810_0000, 32'h10);
        one("bgtz", ID_BGTZ, 5'd4, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0010,
            26'h0, 32'h1C80_0010, 32'h14);
        one("sw", ID_SW, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0, 16'hFFF8,
            26'h0, 32'hAFBF_FFF8, 32'h18);
        chk("seq_count", 32'(word_count), 32'd7);

        // Backpressure stall; base_load during stall is ignored
        out_ready = 1'b0;
        drive(ID_ORI, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0);
        @(negedge Clk);
        idle();
        a_hold = out_addr;
        d_hold = out_data;
        c_hold = word_count;
        chk("stall_data0", d_hold, 32'h3421_00FF);
        base_load = 1'b1;
        base_addr = 32'h800;
        for (int i = 0; i < 3; i++) begin
            drive(ID_ADDI, 5'd2, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
            @(negedge Clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, 32'h3421_00FF);
            chk("stall_addr", out_addr, 32'h1C);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        idle();
        base_load = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        chk("rel_valid", 32'(out_valid), 32'd0);
        chk("rel_addr", out_addr, 32'h20);
        chk("rel_count", 32'(word_count), 32'(c_hold) + 32'd1);

        // Illegal op id
        drive(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0, 26'h0);
        @(negedge Clk);
        idle();
        chk("ill_err", 32'(err_pulse), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        @(negedge Clk);
        chk("ill_err_off", 32'(err_pulse), 32'd0);
        chk("ill_addr", out_addr, 32'h20);
        chk("ill_count", 32'(word_count), 32'd8);

        // base_load while idle
        base_load = 1'b1;
        base_addr = 32'h400;
        @(negedge Clk);
        base_load = 1'b0;
        chk("bl_addr", out_addr, 32'h400);
        chk("bl_count", 32'(word_count), 32'd0);
        one("bl_word", ID_ANDI, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00F0,
            26'h0, 32'h3064_00F0, 32'h400);
        chk("bl_count1", 32'(word_count), 32'd1);

        // Address wrap
        base_load = 1'b1;
        base_addr = 32'hFFFF_FFFC;
        @(negedge Clk);
        base_load = 1'b0;
        one("wrap", ID_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0,
            26'h000_0040, 32'h0C00_0040, 32'hFFFF_FFFC);
        chk("wrap_addr", out_addr, 32'h0);

        // Reset mid-transfer
        base_load = 1'b1;
        base_addr = 32'h100;
        @(negedge Clk);
        base_load = 1'b0;
        out_ready = 1'b0;
        drive(ID_BNE, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0);
        @(negedge Clk);
        idle();
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_data", out_data, 32'h1422_0003);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr", out_addr, 32'h0);
        chk("mid_rst_count", 32'(word_count), 32'd0);
        out_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
